// File: rtl/sd_defs.sv
// Shared definitions for the SD block sequencer: FSM state encodings,
// default block size and watchdog limit, and address/count widths.
package sd_defs;

   localparam int SD_WORDS   = 256;   // 16-bit words per block
   localparam int SD_TIMEOUT = 4000;  // clk400 cycles without reader progress
   localparam int SD_ADDR_W  = 32;    // block address width
   localparam int SD_FILL_W  = 9;     // fill counter width, holds 0..SD_WORDS

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_FILL      = 3'd3,
      ST_DONE      = 3'd4,
      ST_ERR       = 3'd5
   } sd_state_t;

endpackage

// File: rtl/sd_rr_arbiter.sv
// Two-way round-robin arbiter for the shared reader/cache resource.
// On a tie the requester not served last wins; after reset req0 wins.
module sd_rr_arbiter (
   input  logic       clk400,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       en,
   output logic [1:0] gnt
);

   // Index of the requester served last; reset to 1 so req0 wins the first tie.
   logic last_q;

   // One-hot grant, only while enabled (sequencer idle).
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req0 && req1) gnt = last_q ? 2'b01 : 2'b10;
         else if (req0)    gnt = 2'b01;
         else if (req1)    gnt = 2'b10;
      end
   end

   // Pointer follows each grant.
   always_ff @(posedge clk400) begin
      if (reset)     last_q <= 1'b1;
      else if (|gnt) last_q <= gnt[1];
   end

endmodule

// File: rtl/sd_block_sequencer.sv
// SD block sequencer: grants one of two requesters, starts the card reader,
// counts cache write strobes to detect block completion and reports
// done/err to the owner. Optional watchdog enabled by macro SD_TIMEOUT_EN.
//
// Handshake: reqN is a level held until gntN; gntN is a one-cycle accept
// pulse in which blkN is captured. doneN is a one-cycle pulse to the owner,
// with err high in the same cycle when the fetch failed.
module sd_block_sequencer
   import sd_defs::*;
#(
   parameter int WORDS   = SD_WORDS,
   parameter int TIMEOUT = SD_TIMEOUT
) (
   input  logic                 clk400,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [SD_ADDR_W-1:0] blk0,
   input  logic [SD_ADDR_W-1:0] blk1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 done0,
   output logic                 done1,
   output logic                 err,
   output logic                 rdStart,
   output logic [SD_ADDR_W-1:0] rdBlock,
   input  logic                 rdBusy,
   input  logic                 writeCashe,
   output logic [SD_FILL_W-1:0] fillCount,
   output logic                 owner,
   output logic                 valid,
   output sd_state_t            state_dbg
);

   localparam logic [SD_FILL_W-1:0] WORDS_V = SD_FILL_W'(WORDS);

   sd_state_t state_q, state_d;
   logic [1:0] gnt_w;
   logic cnt_en;
   logic [SD_FILL_W-1:0] fill_next;
   logic wd_expire;

   sd_rr_arbiter u_arb (
      .clk400 (clk400),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .en     (state_q == ST_IDLE),
      .gnt    (gnt_w)
   );

   // Writes count only while the reader may be filling; saturate at WORDS.
   assign cnt_en    = (state_q == ST_WAIT_BUSY) || (state_q == ST_FILL);
   assign fill_next = (cnt_en && writeCashe && fillCount != WORDS_V)
                      ? fillCount + SD_FILL_W'(1) : fillCount;
   assign state_dbg = state_q;

`ifdef SD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q;

   assign wd_expire = cnt_en && !writeCashe && (wd_q == WD_W'(TIMEOUT - 1));

   // Watchdog restarts on state entry and on every reader write.
   always_ff @(posedge clk400) begin
      if (reset)                                 wd_q <= '0;
      else if (state_d != state_q || writeCashe) wd_q <= '0;
      else if (cnt_en)                           wd_q <= wd_q + WD_W'(1);
   end
`else
   assign wd_expire = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk400) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a write coinciding with the busy fall is counted first.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (|gnt_w) state_d = ST_START;
         ST_START:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (wd_expire)   state_d = ST_ERR;
            else if (rdBusy) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (!rdBusy)        state_d = (fill_next == WORDS_V) ? ST_DONE : ST_ERR;
            else if (wd_expire) state_d = ST_ERR;
         end
         ST_DONE:      state_d = ST_IDLE;
         ST_ERR:       state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Registered outputs: pulses, latched request data, fill count, valid.
   always_ff @(posedge clk400) begin
      if (reset) begin
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err       <= 1'b0;
         rdStart   <= 1'b0;
         rdBlock   <= '0;
         fillCount <= '0;
         owner     <= 1'b0;
         valid     <= 1'b0;
      end else begin
         gnt0    <= gnt_w[0];
         gnt1    <= gnt_w[1];
         rdStart <= (state_q == ST_START);
         done0   <= (state_q == ST_DONE || state_q == ST_ERR) && !owner;
         done1   <= (state_q == ST_DONE || state_q == ST_ERR) && owner;
         err     <= (state_q == ST_ERR);
         if (|gnt_w) begin
            rdBlock   <= gnt_w[1] ? blk1 : blk0;
            owner     <= gnt_w[1];
            fillCount <= '0;
            valid     <= 1'b0;
         end else if (cnt_en) begin
            fillCount <= fill_next;
         end
         if (state_q == ST_DONE) valid <= 1'b1;
      end
   end

endmodule
